mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port ifReq, input, 1, instruction-fetch request; held high until ifValid.
REQ-004 SHALL have port ifAddr, input, 32, fetch address.
REQ-005 SHALL have port flush, input, 1, pipeline flush; cancels the fetch in flight.
REQ-006 SHALL have port memReq, input, 1, memory-stage request; held high until memValid.
REQ-007 SHALL have port memWrite, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port memAddr, input, 32, data address.
REQ-009 SHALL have port memWdata, input, 32, store data.
REQ-010 SHALL have port ramRdata, input, 32, shared RAM read data.
REQ-011 SHALL have port ramReady, input, 1, RAM completes the current access this cycle.
REQ-012 SHALL have port ramEn, output, 1, RAM access active.
REQ-013 SHALL have port ramWrite, output, 1, RAM write strobe.
REQ-014 SHALL have port ramAddr, output, 32, RAM address.
REQ-015 SHALL have port ramWdata, output, 32, RAM write data.
REQ-016 SHALL have port ifValid, output, 1, one-cycle fetch completion pulse.
REQ-017 SHALL have port ifData, output, 32, fetched word, valid with ifValid.
REQ-018 SHALL have port memValid, output, 1, one-cycle data completion pulse for loads and stores.
REQ-019 SHALL have port memData, output, 32, load data, valid with memValid.
REQ-020 SHALL have port ifStall, output, 1, equal to ifReq & !ifValid.
REQ-021 SHALL have port memStall, output, 1, equal to memReq & !memValid.

Function
REQ-022 SHALL implement states IDLE, IF_BUSY, MEM_BUSY; plus 1-bit drop flag and 1-bit lastMem fairness flag.
REQ-023 In IDLE, grant SHALL go to MEM when memReq & (!ifReq | !lastMem | flush), else to IF when ifReq & !flush; no grant otherwise.
REQ-024 On a grant, the arbiter SHALL register address, write flag and write data at that edge and enter the matching BUSY state.
REQ-025 In a BUSY state, ramEn SHALL be 1 and ramAddr/ramWrite/ramWdata SHALL come from the registered copies, stable until completion.
REQ-026 ramWrite SHALL be 1 only in MEM_BUSY with a registered store; ramWdata SHALL be 0 otherwise.
REQ-027 Completion SHALL be a BUSY cycle with ramReady=1; the next state SHALL be IDLE. Minimum latency: request cycle to valid pulse = 1 cycle.
REQ-028 ifValid SHALL equal (state==IF_BUSY) & ramReady & !drop & !flush; ifData SHALL pass ramRdata.
REQ-029 memValid SHALL equal (state==MEM_BUSY) & ramReady; memData SHALL pass ramRdata for loads and be 0 for stores.
REQ-030 flush in IF_BUSY SHALL set drop; the access SHALL still run to ramReady, ifValid SHALL stay 0, and drop SHALL clear on completion.
REQ-031 flush SHALL NOT affect MEM_BUSY or memory-stage grants.
REQ-032 lastMem SHALL set on MEM completion and clear on IF completion, including dropped fetches.
REQ-033 ramReady in IDLE SHALL be ignored.
REQ-034 Outputs with unmet conditions SHALL be 0.

Reset
REQ-035 While rst=0, state SHALL be IDLE, drop=0, lastMem=0, and registered address/data=0. All outputs SHALL be 0 except ifStall/memStall, which follow REQ-020/021.
REQ-036 Reset asserted mid-transaction SHALL abandon that transaction with no valid pulse. After release, arbitration SHALL restart from IDLE.

Verification
REQ-037 The bench SHALL cover these cases:
- Lone fetch: ifReq=1, ifAddr=0x00000040, ramReady=1 in first BUSY cycle, ramRdata=0x8C220004 -> ramEn/ramAddr=0x40 for 1 cycle; ifValid=1 and ifData=0x8C220004 at that cycle; ifStall=1 the cycle before.
- Both request, lastMem=0: memReq=1 (load 0x100), ifReq=1 -> MEM served first; memStall=0 at completion; IF granted next IDLE even with memReq re-raised (lastMem=1).
- Store with wait: memWrite=1, memAddr=0x200, memWdata=0xDEADBEEF, ramReady low 3 cycles -> ramWrite=1, address/data stable 4 cycles; memValid one pulse; memData=0.
- Flush in flight: fetch granted, flush=1 in 2nd IF_BUSY cycle, ramReady in 3rd -> ifValid never 1; IDLE afterwards; new fetch served normally.
- Flush in IDLE with ifReq=1, memReq=0 -> no grant that cycle; grant the following cycle.
- Reset mid-access: rst=0 during MEM_BUSY -> ramEn=0 immediately, no memValid; after release with memReq=1, new grant within 1 cycle.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/memory stages, the arbiter and the shared RAM.
// The slave view belongs to the arbiter. The master view belongs to the surrounding pipeline and RAM.
interface mem_arbiter_if;
  logic        ifReq;
  logic [31:0] ifAddr;
  logic        flush;
  logic        memReq;
  logic        memWrite;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [31:0] ramRdata;
  logic        ramReady;
  logic        ramEn;
  logic        ramWrite;
  logic [31:0] ramAddr;
  logic [31:0] ramWdata;
  logic        ifValid;
  logic [31:0] ifData;
  logic        memValid;
  logic [31:0] memData;
  logic        ifStall;
  logic        memStall;

  modport slave (
    input  ifReq, ifAddr, flush, memReq, memWrite, memAddr, memWdata, ramRdata, ramReady,
    output ramEn, ramWrite, ramAddr, ramWdata, ifValid, ifData, memValid, memData,
           ifStall, memStall
  );

  modport master (
    output ifReq, ifAddr, flush, memReq, memWrite, memAddr, memWdata, ramRdata, ramReady,
    input  ramEn, ramWrite, ramAddr, ramWdata, ifValid, ifData, memValid, memData,
           ifStall, memStall
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and the memory stage.
// Grants alternate under contention, and a flush cancels a fetch that is already in flight.
module mem_arbiter (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_t;

  state_t      state;
  logic        drop;
  logic        lastMem;
  logic        regWrite;
  logic [31:0] regAddr;
  logic [31:0] regWdata;

  logic        memGrant;
  logic        ifGrant;
  logic        busy;

  // Memory wins unless fetch is also waiting and memory was served last; a flush never blocks it.
  always_comb begin
    memGrant = bus.memReq & (!bus.ifReq | !lastMem | bus.flush);
    ifGrant  = bus.ifReq & !bus.flush & !memGrant;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      drop     <= 1'b0;
      lastMem  <= 1'b0;
      regWrite <= 1'b0;
      regAddr  <= '0;
      regWdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (memGrant) begin
            state    <= MEM_BUSY;
            regAddr  <= bus.memAddr;
            regWrite <= bus.memWrite;
            regWdata <= bus.memWrite ? bus.memWdata : 32'h0;
          end else if (ifGrant) begin
            state    <= IF_BUSY;
            regAddr  <= bus.ifAddr;
            regWrite <= 1'b0;
            regWdata <= '0;
          end
        end
        IF_BUSY: begin
          // A cancelled fetch still runs to completion so the RAM sees a clean access.
          if (bus.ramReady) begin
            state   <= IDLE;
            drop    <= 1'b0;
            lastMem <= 1'b0;
          end else if (bus.flush) begin
            drop <= 1'b1;
          end
        end
        MEM_BUSY: begin
          if (bus.ramReady) begin
            state   <= IDLE;
            lastMem <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy         = (state != IDLE);
  assign bus.ramEn    = busy;
  assign bus.ramWrite = (state == MEM_BUSY) & regWrite;
  assign bus.ramAddr  = busy ? regAddr : 32'h0;
  assign bus.ramWdata = bus.ramWrite ? regWdata : 32'h0;

  assign bus.ifValid  = (state == IF_BUSY) & bus.ramReady & !drop & !bus.flush;
  assign bus.ifData   = bus.ifValid ? bus.ramRdata : 32'h0;
  assign bus.memValid = (state == MEM_BUSY) & bus.ramReady;
  assign bus.memData  = (bus.memValid & !regWrite) ? bus.ramRdata : 32'h0;

  assign bus.ifStall  = bus.ifReq & !bus.ifValid;
  assign bus.memStall = bus.memReq & !bus.memValid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: drives inputs on the falling edge and checks just after.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   checkCount;
  int   passCount;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr, input logic flush,
                               input logic memReq, input logic memWrite, input logic [31:0] memAddr,
                               input logic [31:0] memWdata, input logic ramReady,
                               input logic [31:0] ramRdata);
    bus.ifReq    = ifReq;
    bus.ifAddr   = ifAddr;
    bus.flush    = flush;
    bus.memReq   = memReq;
    bus.memWrite = memWrite;
    bus.memAddr  = memAddr;
    bus.memWdata = memWdata;
    bus.ramReady = ramReady;
    bus.ramRdata = ramRdata;
    #1;
  endtask

  task automatic nextCycle;
    @(negedge clk);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst        = 1'b0;

    // Reset: only the stall outputs may be nonzero.
    applyStimulus(1, 32'h10, 0, 0, 0, 0, 0, 1, 32'h5555AAAA);
    checkOutput("rst_ramEn", bus.ramEn, 0);
    checkOutput("rst_ifValid", bus.ifValid, 0);
    checkOutput("rst_ifData", bus.ifData, 0);
    checkOutput("rst_ifStall", bus.ifStall, 1);
    checkOutput("rst_memStall", bus.memStall, 0);
    nextCycle;
    rst = 1'b1;

    // Lone fetch
    applyStimulus(1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("lone_stall_before", bus.ifStall, 1);
    checkOutput("lone_idle_ramEn", bus.ramEn, 0);
    nextCycle;
    applyStimulus(1, 32'h40, 0, 0, 0, 0, 0, 1, 32'h8C220004);
    checkOutput("lone_ramEn", bus.ramEn, 1);
    checkOutput("lone_ramAddr", bus.ramAddr, 32'h40);
    checkOutput("lone_ramWrite", bus.ramWrite, 0);
    checkOutput("lone_ifValid", bus.ifValid, 1);
    checkOutput("lone_ifData", bus.ifData, 32'h8C220004);
    checkOutput("lone_ifStall", bus.ifStall, 0);
    nextCycle;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("lone_after_ramEn", bus.ramEn, 0);
    checkOutput("lone_after_ifValid", bus.ifValid, 0);

    // Both request with lastMem=0: memory first, then fetch
    applyStimulus(1, 32'h44, 0, 1, 0, 32'h100, 0, 0, 0);
    checkOutput("both_idle_ramEn", bus.ramEn, 0);
    nextCycle;
    applyStimulus(1, 32'h44, 0, 1, 0, 32'h100, 0, 1, 32'h11112222);
    checkOutput("both_mem_addr", bus.ramAddr, 32'h100);
    checkOutput("both_memValid", bus.memValid, 1);
    checkOutput("both_memData", bus.memData, 32'h11112222);
    checkOutput("both_memStall", bus.memStall, 0);
    checkOutput("both_ifStall", bus.ifStall, 1);
    checkOutput("both_ifValid", bus.ifValid, 0);
    nextCycle;
    applyStimulus(1, 32'h44, 0, 1, 0, 32'h104, 0, 0, 0);
    checkOutput("both_gap_ramEn", bus.ramEn, 0);
    nextCycle;
    applyStimulus(1, 32'h44, 0, 1, 0, 32'h104, 0, 1, 32'h0000AAAA);
    checkOutput("both_if_addr", bus.ramAddr, 32'h44);
    checkOutput("both_if_valid", bus.ifValid, 1);
    checkOutput("both_if_data", bus.ifData, 32'h0000AAAA);
    checkOutput("both_if_memValid", bus.memValid, 0);
    checkOutput("both_if_memStall", bus.memStall, 1);
    nextCycle;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("both_end_ramEn", bus.ramEn, 0);

    // Store with three wait cycles; live address/data are scrambled after the grant
    applyStimulus(0, 0, 0, 1, 1, 32'h200, 32'hDEADBEEF, 0, 0);
    nextCycle;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 1, 1, 32'h999, 32'h12345678, (i == 3), 32'hFFFF0000);
      checkOutput("st_ramEn", bus.ramEn, 1);
      checkOutput("st_ramWrite", bus.ramWrite, 1);
      checkOutput("st_ramAddr", bus.ramAddr, 32'h200);
      checkOutput("st_ramWdata", bus.ramWdata, 32'hDEADBEEF);
      checkOutput("st_memValid", bus.memValid, (i == 3));
      checkOutput("st_memData", bus.memData, 0);
      nextCycle;
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("st_end_ramEn", bus.ramEn, 0);
    checkOutput("st_end_ramWrite", bus.ramWrite, 0);
    checkOutput("st_end_ramWdata", bus.ramWdata, 0);
    checkOutput("st_end_memValid", bus.memValid, 0);

    // Flush in flight
    applyStimulus(1, 32'h80, 0, 0, 0, 0, 0, 0, 0);
    nextCycle;
    applyStimulus(1, 32'h80, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("fl_busy1_addr", bus.ramAddr, 32'h80);
    nextCycle;
    applyStimulus(1, 32'h90, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("fl_busy2_ifValid", bus.ifValid, 0);
    checkOutput("fl_busy2_ramEn", bus.ramEn, 1);
    nextCycle;
    applyStimulus(1, 32'h90, 0, 0, 0, 0, 0, 1, 32'hBAD0BAD0);
    checkOutput("fl_busy3_ifValid", bus.ifValid, 0);
    checkOutput("fl_busy3_ifData", bus.ifData, 0);
    checkOutput("fl_busy3_ramAddr", bus.ramAddr, 32'h80);
    nextCycle;
    applyStimulus(1, 32'h90, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("fl_idle_ramEn", bus.ramEn, 0);
    nextCycle;
    applyStimulus(1, 32'h90, 0, 0, 0, 0, 0, 1, 32'h600D600D);
    checkOutput("fl_new_addr", bus.ramAddr, 32'h90);
    checkOutput("fl_new_ifValid", bus.ifValid, 1);
    checkOutput("fl_new_ifData", bus.ifData, 32'h600D600D);
    nextCycle;

    // Flush in IDLE blocks the fetch grant for one cycle; ramReady in IDLE is ignored
    applyStimulus(1, 32'hA0, 1, 0, 0, 0, 0, 1, 32'h77777777);
    checkOutput("fi_flush_ramEn", bus.ramEn, 0);
    checkOutput("fi_flush_ifValid", bus.ifValid, 0);
    nextCycle;
    applyStimulus(1, 32'hA0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("fi_nogrant_ramEn", bus.ramEn, 0);
    nextCycle;
    applyStimulus(1, 32'hA0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D);
    checkOutput("fi_grant_ramEn", bus.ramEn, 1);
    checkOutput("fi_grant_addr", bus.ramAddr, 32'hA0);
    checkOutput("fi_grant_ifValid", bus.ifValid, 1);
    nextCycle;

    // Reset in the middle of a load
    applyStimulus(0, 0, 0, 1, 0, 32'h300, 0, 0, 0);
    nextCycle;
    applyStimulus(0, 0, 0, 1, 0, 32'h300, 0, 0, 0);
    checkOutput("rm_busy_ramEn", bus.ramEn, 1);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 1, 0, 32'h300, 0, 1, 32'h33333333);
    checkOutput("rm_rst_ramEn", bus.ramEn, 0);
    checkOutput("rm_rst_memValid", bus.memValid, 0);
    checkOutput("rm_rst_memStall", bus.memStall, 1);
    nextCycle;
    rst = 1'b1;
    applyStimulus(0, 0, 0, 1, 0, 32'h300, 0, 0, 0);
    checkOutput("rm_rel_ramEn", bus.ramEn, 0);
    nextCycle;
    applyStimulus(0, 0, 0, 1, 0, 32'h300, 0, 1, 32'h44444444);
    checkOutput("rm_regrant_ramEn", bus.ramEn, 1);
    checkOutput("rm_regrant_addr", bus.ramAddr, 32'h300);
    checkOutput("rm_regrant_memValid", bus.memValid, 1);
    checkOutput("rm_regrant_memData", bus.memData, 32'h44444444);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
